// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the access-size and FSM state enums, the lane count and the lane decode helpers.
// Pure declarations; no timing or flow control of its own.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = DATA_W / 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    // Raw request size to enum; the unused 2'b11 encoding behaves as a word.
    function automatic size_t decode_size(input logic [1:0] raw);
        size_t s;
        case (raw)
            2'b00:   s = SIZE_B;
            2'b01:   s = SIZE_H;
            default: s = SIZE_W;
        endcase
        return s;
    endfunction

    // Byte enables for an access of the given size at the given (aligned) lane.
    function automatic logic [LANES-1:0] byte_strobe(input size_t size, input logic [1:0] lane);
        logic [LANES-1:0] s;
        case (size)
            SIZE_B:  s = LANES'(1) << lane;
            SIZE_H:  s = lane[1] ? 4'b1100 : 4'b0011;
            default: s = '1;
        endcase
        return s;
    endfunction

    // True when the low address bits are not a multiple of the access size.
    function automatic logic misaligned(input size_t size, input logic [1:0] lane);
        logic m;
        case (size)
            SIZE_B:  m = 1'b0;
            SIZE_H:  m = lane[0];
            default: m = |lane;
        endcase
        return m;
    endfunction

    // Force the address bits below the access size to zero.
    function automatic logic [1:0] align_lane(input size_t size, input logic [1:0] lane);
        logic [1:0] a;
        case (size)
            SIZE_B:  a = lane;
            SIZE_H:  a = {lane[1], 1'b0};
            default: a = 2'b00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Store lane steering: right-justified store data placed into its byte lanes and merged over the old word.
// Purely combinational, zero latency.
// No handshake; the parent decides when the merged word is written.
module store_lane_merge
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  size_t              size,
    input  logic [1:0]         lane,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH-1:0]   old_word,
    output logic [WIDTH-1:0]   shifted,
    output logic [LANES-1:0]   strobe,
    output logic [WIDTH-1:0]   merged
);

    logic [WIDTH-1:0] masked;

    assign strobe = byte_strobe(size, lane);

    // Drop bits above the access size, then shift into the target lane.
    always_comb begin
        masked  = wdata;
        shifted = wdata;
        case (size)
            SIZE_B: begin
                masked  = wdata & WIDTH'(8'hFF);
                shifted = masked << {lane, 3'b000};
            end
            SIZE_H: begin
                masked  = wdata & WIDTH'(16'hFFFF);
                shifted = masked << {lane[1], 4'b0000};
            end
            default: ;
        endcase
    end

    // Enabled lanes take new data, the rest keep the old word.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (strobe[i]) merged[i*8 +: 8] = shifted[i*8 +: 8];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding data-memory responder with byte-addressed storage; optional MISALIGN_CHECK_EN flags misaligned accesses.
// Response LATENCY cycles after acceptance (1..15); one request per LATENCY+1 cycles at best.
// req_ready only in IDLE; response held in RESP until resp_ready.
module mem_responder
    import mem_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t                state, next_state;
    logic [3:0]            cnt;
    logic                  finish;

    logic                  we_q;
    size_t                 size_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;

    // The operation being completed: live request when LATENCY=1 commits at acceptance, else the captured one.
    logic                  op_we;
    size_t                 op_size;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [WIDTH-1:0]      op_wdata;
    logic                  op_err;
    logic [1:0]            op_lane;
    logic [WIDTH-1:0]      old_word;
    logic [WIDTH-1:0]      store_data;
    logic [LANES-1:0]      store_strobe;
    logic [WIDTH-1:0]      merged_word;
    logic                  unused_bits;

    assign op_we    = (state == BUSY) ? we_q    : req_we;
    assign op_size  = (state == BUSY) ? size_q  : decode_size(req_size);
    assign op_addr  = (state == BUSY) ? addr_q  : req_addr[ADDR_WIDTH-1:0];
    assign op_wdata = (state == BUSY) ? wdata_q : req_wdata;
    assign op_lane  = align_lane(op_size, op_addr[1:0]);
    assign old_word = mem[op_addr[ADDR_WIDTH-1:2]];

`ifdef MISALIGN_CHECK_EN
    assign op_err = misaligned(op_size, op_addr[1:0]);
`else
    assign op_err = 1'b0;
`endif

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // Address bits above the decoded range alias away; the strobe is only needed inside the merge.
    assign unused_bits = ^{req_addr[WIDTH-1:ADDR_WIDTH], store_data, store_strobe};

    store_lane_merge #(.WIDTH(WIDTH)) u_merge (
        .size     (op_size),
        .lane     (op_lane),
        .wdata    (op_wdata),
        .old_word (old_word),
        .shifted  (store_data),
        .strobe   (store_strobe),
        .merged   (merged_word)
    );

    // Next-state decode; finish marks the edge that commits the store or samples the load.
    always_comb begin
        next_state = state;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        next_state = RESP;
                        finish     = 1'b1;
                    end else begin
                        next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    next_state = RESP;
                    finish     = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State, latency counter, request capture and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            size_q     <= SIZE_B;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                size_q  <= decode_size(req_size);
                addr_q  <= req_addr[ADDR_WIDTH-1:0];
                wdata_q <= req_wdata;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (finish) begin
                resp_rdata <= (op_we || op_err) ? '0 : old_word;
                resp_err   <= op_err;
            end
        end
    end

    // Storage is never reset; a store lands only on its completing edge, so a reset in BUSY discards it.
    always_ff @(posedge clk) begin
        if (finish && rst_n && op_we && !op_err) begin
            mem[op_addr[ADDR_WIDTH-1:2]] <= merged_word;
        end
    end

endmodule
